// File: rtl/axi_sram_slave.sv
// AXI-style SRAM slave: single outstanding INCR burst (read or write) against
// an internal 2^ADDR_W x 32-bit word RAM, with round-robin AR/AW arbitration
// and SLVERR for beats that fall outside the RAM.
module axi_sram_slave #(
    parameter int ADDR_W = 14
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        WR_DATA = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    localparam logic GRANT_READ  = 1'b0;
    localparam logic GRANT_WRITE = 1'b1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic [3:0]  id_q, id_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  beat_q, beat_d;
    logic        wr_err_q, wr_err_d;
    logic [3:0]  rid_q, rid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;
    logic [3:0]  bid_q, bid_d;
    logic [1:0]  bresp_q, bresp_d;

    logic [31:0] mem [1 << ADDR_W];

    logic [ADDR_W-1:0] word_idx;
    logic              addr_oor;
    logic              ar_hs;
    logic              aw_hs;
    logic              w_hs;
    logic              wr_en;
    logic              unused_wlast;

    // Burst termination is driven purely by the beat counter.
    assign unused_wlast = wlast;

    assign word_idx = addr_q[ADDR_W+1:2];
    assign addr_oor = |(addr_q >> (ADDR_W + 2));

    // Address channel arbitration: the channel not granted last wins a collision.
    assign arready = aresetn && (state_q == IDLE) && arvalid &&
                     (!awvalid || (grant_q == GRANT_WRITE));
    assign awready = aresetn && (state_q == IDLE) && awvalid &&
                     (!arvalid || (grant_q == GRANT_READ));

    assign wready  = (state_q == WR_DATA);
    assign rvalid  = (state_q == RD_DATA);
    assign bvalid  = (state_q == WR_RESP);

    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;

    assign ar_hs = arvalid && arready;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign wr_en = w_hs && !addr_oor;

    // Next-state and burst bookkeeping for the transaction FSM.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        beat_d   = beat_q;
        wr_err_d = wr_err_q;
        rid_d    = rid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        bid_d    = bid_q;
        bresp_d  = bresp_q;

        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    id_d    = arid;
                    addr_d  = araddr;
                    len_d   = arlen;
                    beat_d  = 8'd0;
                    grant_d = GRANT_READ;
                    state_d = RD_REQ;
                end else if (aw_hs) begin
                    id_d     = awid;
                    addr_d   = awaddr;
                    len_d    = awlen;
                    beat_d   = 8'd0;
                    wr_err_d = 1'b0;
                    grant_d  = GRANT_WRITE;
                    state_d  = WR_DATA;
                end
            end
            RD_REQ: begin
                // Registered read: the beat is presented from flops in RD_DATA.
                rid_d   = id_q;
                rdata_d = addr_oor ? 32'd0 : mem[word_idx];
                rresp_d = addr_oor ? RESP_SLVERR : RESP_OKAY;
                rlast_d = (beat_q == len_q);
                state_d = RD_DATA;
            end
            RD_DATA: begin
                if (rready) begin
                    if (rlast_q) begin
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        addr_d  = addr_q + 32'd4;
                        state_d = RD_REQ;
                    end
                end
            end
            WR_DATA: begin
                if (wvalid) begin
                    wr_err_d = wr_err_q || addr_oor;
                    beat_d   = beat_q + 8'd1;
                    addr_d   = addr_q + 32'd4;
                    if (beat_q == len_q) begin
                        bid_d   = id_q;
                        bresp_d = (wr_err_q || addr_oor) ? RESP_SLVERR : RESP_OKAY;
                        state_d = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (bready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and response registers; reset aborts any burst in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            grant_q  <= GRANT_WRITE;
            id_q     <= 4'd0;
            addr_q   <= 32'd0;
            len_q    <= 8'd0;
            beat_q   <= 8'd0;
            wr_err_q <= 1'b0;
            rid_q    <= 4'd0;
            rdata_q  <= 32'd0;
            rresp_q  <= 2'b00;
            rlast_q  <= 1'b0;
            bid_q    <= 4'd0;
            bresp_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            wr_err_q <= wr_err_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
            bid_q    <= bid_d;
            bresp_q  <= bresp_d;
        end
    end

    // RAM byte-lane writes on each accepted in-range W beat.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
